// File: rtl/data_bus_xbar.sv
// data_bus_xbar: N-master round-robin shared bus with base/mask slave decode,
// decode-error response and slave timeout watchdog; one transaction at a time.
module data_bus_xbar #(
    parameter int NMST = 2,
    parameter int NSLV = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NSLV-1:0] SLV_EN = '1,
    parameter logic [NSLV*ADDR_W-1:0] SLV_BADR = '0,
    parameter logic [NSLV*ADDR_W-1:0] SLV_MADR = '0,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NMST-1:0]          m_req,
    input  logic [NMST-1:0]          m_we,
    input  logic [NMST*ADDR_W-1:0]   m_addr,
    input  logic [NMST*DATA_W-1:0]   m_wdata,
    input  logic [NMST*DATA_W/8-1:0] m_be,
    output logic [DATA_W-1:0]        m_rdata,
    output logic [NMST-1:0]          m_ack,
    output logic [NMST-1:0]          m_err,
    output logic [NSLV-1:0]          s_sel,
    output logic                     s_we,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [DATA_W/8-1:0]      s_be,
    input  logic [NSLV*DATA_W-1:0]   s_rdata,
    input  logic [NSLV-1:0]          s_ack
);
    localparam int BE_W = DATA_W / 8;
    localparam int MW = NMST > 1 ? $clog2(NMST) : 1;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              r_state, w_next;
    logic [MW-1:0]       r_rr, r_gnt, w_gnt, w_off, w_rr_nxt;
    logic [2*NMST-1:0]   w_rot;
    logic [MW:0]         w_sum;
    logic                r_we, w_we, r_err, w_ack, w_to;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata, r_rdata, w_srdata;
    logic [BE_W-1:0]     r_be, w_be;
    logic [NSLV-1:0]     r_sel, w_sel;
    logic [CW-1:0]       r_cnt;

    // Rotating the request vector by rr turns the wrap-around search into a lowest-bit search.
    always_comb begin
        w_rot = {m_req, m_req} >> r_rr;
        w_off = '0;
        for (int k = NMST - 1; k >= 0; k--)
            if (w_rot[k]) w_off = MW'(k);
        w_sum = {1'b0, r_rr} + {1'b0, w_off};
        w_gnt = (w_sum >= (MW+1)'(NMST)) ? MW'(w_sum - (MW+1)'(NMST)) : MW'(w_sum);
        w_rr_nxt = (r_gnt == MW'(NMST - 1)) ? '0 : r_gnt + 1'b1;
    end

    always_comb begin
        w_we = 1'b0;
        w_addr = '0;
        w_wdata = '0;
        w_be = '0;
        for (int k = 0; k < NMST; k++)
            if (w_gnt == MW'(k)) begin
                w_we = m_we[k];
                w_addr = m_addr[k*ADDR_W +: ADDR_W];
                w_wdata = m_wdata[k*DATA_W +: DATA_W];
                w_be = m_be[k*BE_W +: BE_W];
            end
    end

    // Descending scan so the lowest matching slave index has the final say.
    always_comb begin
        w_sel = '0;
        for (int k = NSLV - 1; k >= 0; k--)
            if (SLV_EN[k] && ((w_addr & SLV_MADR[k*ADDR_W +: ADDR_W]) ==
                              (SLV_BADR[k*ADDR_W +: ADDR_W] & SLV_MADR[k*ADDR_W +: ADDR_W])))
                w_sel = NSLV'(1) << k;
    end

    always_comb begin
        w_srdata = '0;
        for (int k = 0; k < NSLV; k++)
            if (r_sel[k]) w_srdata = s_rdata[k*DATA_W +: DATA_W];
        w_ack = |(s_ack & r_sel);
        w_to = (TIMEOUT != 0) && (int'(r_cnt) + 1 == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|m_req) w_next = (|w_sel) ? BUSY : RESP;
            BUSY:    if (w_ack || w_to) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr <= '0;
            r_gnt <= '0;
            r_we <= 1'b0;
            r_addr <= '0;
            r_wdata <= '0;
            r_be <= '0;
            r_sel <= '0;
            r_err <= 1'b0;
            r_rdata <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (|m_req) begin
                    r_gnt <= w_gnt;
                    r_we <= w_we;
                    r_addr <= w_addr;
                    r_wdata <= w_wdata;
                    r_be <= w_be;
                    r_sel <= w_sel;
                    r_err <= ~|w_sel;
                    r_rdata <= '0;
                    r_cnt <= '0;
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ack) r_rdata <= w_srdata;
                    else if (w_to) r_err <= 1'b1;
                end
                RESP: begin
                    r_rr <= w_rr_nxt;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_sel = (r_state == BUSY) ? r_sel : '0;
        s_we = (r_state == BUSY) && r_we;
        s_addr = (r_state == BUSY) ? r_addr : '0;
        s_wdata = (r_state == BUSY) ? r_wdata : '0;
        s_be = (r_state == BUSY) ? r_be : '0;
        m_ack = (r_state == RESP && !r_err) ? NMST'(1) << r_gnt : '0;
        m_err = (r_state == RESP && r_err) ? NMST'(1) << r_gnt : '0;
        m_rdata = (r_state == RESP && !r_err && !r_we) ? r_rdata : '0;
    end
endmodule

// File: tb/tb_data_bus_xbar.sv
// tb_data_bus_xbar: directed bench for data_bus_xbar; stimulus pushes expected
// slave-side and master-side events into queues that a negedge monitor checks.
module tb_data_bus_xbar;
    localparam logic [3:0]   EN   = 4'b0111;
    localparam logic [127:0] BADR = {32'h00F0_0000, 32'h0001_1000, 32'h0000_1000, 32'h0001_0000};
    localparam logic [127:0] MADR = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

    typedef struct {int cyc; logic [1:0] ack; logic [1:0] err; logic [31:0] rdata;} mexp_t;
    typedef struct {int cyc; logic [3:0] sel; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} sexp_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [1:0]   m_req = '0, m_we = '0, m_ack, m_err;
    logic [63:0]  m_addr = '0, m_wdata = '0;
    logic [7:0]   m_be = '0;
    logic [31:0]  m_rdata, s_addr, s_wdata;
    logic [3:0]   s_sel, s_be, s_ack, mute = '0, noise = '0, prev_sel;
    logic         s_we;
    logic [127:0] s_rdata;
    int           cyc = 0, n_tests = 0, n_fail = 0;
    mexp_t        mq[$];
    sexp_t        sq[$];
    mexp_t        me;
    sexp_t        se;

    data_bus_xbar #(.NMST(2), .NSLV(4), .ADDR_W(32), .DATA_W(32), .SLV_EN(EN),
                    .SLV_BADR(BADR), .SLV_MADR(MADR), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    // Slaves ack in their first selected cycle unless muted; noise drives unselected acks.
    assign s_ack = (s_sel & ~mute) | noise;
    assign s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_0000};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((m_ack | m_err) != 2'b00) begin
            n_tests++;
            if (mq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp cyc=%0d ack=%b err=%b, want no response", cyc, m_ack, m_err);
            end else begin
                me = mq.pop_front();
                if (cyc != me.cyc || m_ack !== me.ack || m_err !== me.err || m_rdata !== me.rdata || s_sel !== 4'b0) begin
                    n_fail++;
                    $display("FAIL resp got cyc=%0d ack=%b err=%b rdata=%h s_sel=%b, want cyc=%0d ack=%b err=%b rdata=%h s_sel=0000",
                             cyc, m_ack, m_err, m_rdata, s_sel, me.cyc, me.ack, me.err, me.rdata);
                end
            end
        end
        if (s_sel != 4'b0 && prev_sel == 4'b0) begin
            n_tests++;
            if (sq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sel cyc=%0d s_sel=%b, want 0000", cyc, s_sel);
            end else begin
                se = sq.pop_front();
                if (cyc != se.cyc || s_sel !== se.sel || s_we !== se.we || s_addr !== se.addr || s_wdata !== se.wdata || s_be !== se.be) begin
                    n_fail++;
                    $display("FAIL slave got cyc=%0d sel=%b we=%b addr=%h wdata=%h be=%b, want cyc=%0d sel=%b we=%b addr=%h wdata=%h be=%b",
                             cyc, s_sel, s_we, s_addr, s_wdata, s_be, se.cyc, se.sel, se.we, se.addr, se.wdata, se.be);
                end
            end
        end
        prev_sel = s_sel;
    end

    task automatic set_m(input int i, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        m_req[i] = req;
        m_we[i] = we;
        m_addr[i*32 +: 32] = a;
        m_wdata[i*32 +: 32] = d;
        m_be[i*4 +: 4] = be;
    endtask

    task automatic exp_s(input int c, input logic [3:0] sel, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        sq.push_back(sexp_t'{c, sel, we, a, d, be});
    endtask

    task automatic exp_m(input int c, input logic [1:0] ack, input logic [1:0] err, input logic [31:0] rd);
        mq.push_back(mexp_t'{c, ack, err, rd});
    endtask

    // Single transaction on an idle bus; lat is the drive-to-response distance in cycles.
    task automatic tx(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [3:0] sel, input int lat,
                      input logic is_err, input logic [31:0] rd);
        int k;
        logic [1:0] oh;
        k = cyc;
        oh = 2'(1) << i;
        set_m(i, 1'b1, we, a, d, be);
        if (sel != 4'b0) exp_s(k + 1, sel, we, a, d, be);
        exp_m(k + lat, is_err ? 2'b00 : oh, is_err ? oh : 2'b00, rd);
        repeat (lat + 1) @(posedge clk);
        #1;
        set_m(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic chk_zero(input string name);
        n_tests++;
        if ({s_sel, s_we, s_addr, s_wdata, s_be, m_ack, m_err, m_rdata} !== 109'b0) begin
            n_fail++;
            $display("FAIL %s outputs got sel=%b we=%b addr=%h wdata=%h be=%b ack=%b err=%b rdata=%h, want all 0",
                     name, s_sel, s_we, s_addr, s_wdata, s_be, m_ack, m_err, m_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        tx(0, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 4'b0010, 2, 1'b0, 32'hDEAD_BEEF);
        tx(1, 1'b1, 32'h0001_2344, 32'h5555_AAAA, 4'b0011, 4'b0001, 2, 1'b0, 32'h0);
        // Both masters keep requesting: grants alternate, three cycles per transaction.
        k = cyc;
        set_m(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        exp_s(k + 1, 4'b0010, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        exp_m(k + 2, 2'b01, 2'b00, 32'hDEAD_BEEF);
        exp_s(k + 4, 4'b0001, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        exp_m(k + 5, 2'b10, 2'b00, 32'hA0A0_0000);
        exp_s(k + 7, 4'b0010, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        exp_m(k + 8, 2'b01, 2'b00, 32'hDEAD_BEEF);
        exp_s(k + 10, 4'b0001, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        exp_m(k + 11, 2'b10, 2'b00, 32'hA0A0_0000);
        repeat (12) @(posedge clk);
        #1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tx(0, 1'b0, 32'h0001_1000, 32'h0, 4'hF, 4'b0001, 2, 1'b0, 32'hA0A0_0000);
        tx(0, 1'b1, 32'h00F0_0000, 32'h1234_5678, 4'hF, 4'b0000, 1, 1'b1, 32'h0);
        tx(1, 1'b0, 32'h0050_0000, 32'h0, 4'hF, 4'b0000, 1, 1'b1, 32'h0);
        mute = 4'b0010;
        noise = 4'b1101;
        tx(1, 1'b0, 32'h0000_1008, 32'h0, 4'hF, 4'b0010, 5, 1'b1, 32'h0);
        mute = 4'b0000;
        noise = 4'b0000;
        tx(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 4'b0010, 2, 1'b0, 32'hDEAD_BEEF);
        // Abort a BUSY transaction with reset; rr returns to 0 so M0 wins the next contest.
        mute = 4'b0010;
        k = cyc;
        set_m(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        exp_s(k + 1, 4'b0010, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        chk_zero("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mute = 4'b0000;
        k = cyc;
        set_m(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
        exp_s(k + 1, 4'b0001, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        exp_m(k + 2, 2'b01, 2'b00, 32'hA0A0_0000);
        exp_s(k + 4, 4'b0010, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
        exp_m(k + 5, 2'b10, 2'b00, 32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tx(1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 4'b0010, 2, 1'b0, 32'hDEAD_BEEF);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (mq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL pending got resp=%0d sel=%0d outstanding, want 0 0", mq.size(), sq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
